// File: rtl/si_pkg.sv
// Shared types and default timing constants for the button conditioner.
package si_pkg;

    // Per-channel debounce / auto-repeat FSM states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_HELD       = 3'd2,
        ST_REPEATING  = 3'd3,
        ST_RELEASE_DB = 3'd4
    } btn_state_t;

    // Defaults assume a 100 MHz clock
    localparam int DEF_N_BTN           = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 10 ms
    localparam int DEF_REPEAT_DELAY    = 50000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 10000000;  // 100 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: input synchroniser followed by the debounce and
// auto-repeat state machine. All outputs are registered.
module btn_channel
    import si_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic repeat_en,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [DW-1:0] D_SAT   = '1;
    localparam logic [RW-1:0] R_SAT   = '1;

    logic                   raw_in;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;

    btn_state_t    state_reg, state_next;
    logic [DW-1:0] dcnt_reg, dcnt_next;
    logic [RW-1:0] rcnt_reg, rcnt_next;
    logic          level_reg, level_next;
    logic          press_reg, press_next;
    logic          release_reg, release_next;
    logic          repeat_reg, repeat_next;
    logic [DW-1:0] dcnt_inc;
    logic [RW-1:0] rcnt_inc;

    // The synchroniser always works on the "pressed = 1" polarity, so its
    // reset value of 0 is the inactive level regardless of ACTIVE_LOW.
    assign raw_in = ACTIVE_LOW ? ~raw : raw;
    assign s      = sync_reg[SYNC_STAGES-1];

    // Counters stick at all-ones instead of wrapping
    assign dcnt_inc = (dcnt_reg == D_SAT) ? dcnt_reg : dcnt_reg + 1'b1;
    assign rcnt_inc = (rcnt_reg == R_SAT) ? rcnt_reg : rcnt_reg + 1'b1;

    // Shift the raw level through the synchroniser chain
    always_ff @(posedge clk) begin
        if (rst) sync_reg <= '0;
        else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in};
    end

    // Next-state logic: debounce both edges, then count toward repeat pulses
    always_comb begin
        state_next   = state_reg;
        dcnt_next    = dcnt_reg;
        rcnt_next    = rcnt_reg;
        level_next   = level_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        repeat_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (s) begin
                    state_next = ST_PRESS_DB;
                    dcnt_next  = '0;
                end
            end
            ST_PRESS_DB: begin
                if (!s) begin
                    state_next = ST_IDLE;
                end else if (dcnt_reg == D_LAST) begin
                    state_next = ST_HELD;
                    press_next = 1'b1;
                    level_next = 1'b1;
                    rcnt_next  = '0;
                end else begin
                    dcnt_next = dcnt_inc;
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_next = ST_RELEASE_DB;
                    dcnt_next  = '0;
                end else if (!repeat_en) begin
                    rcnt_next = '0;
                end else if (rcnt_reg == RD_LAST) begin
                    state_next  = ST_REPEATING;
                    repeat_next = 1'b1;
                    rcnt_next   = '0;
                end else begin
                    rcnt_next = rcnt_inc;
                end
            end
            ST_REPEATING: begin
                if (!s) begin
                    state_next = ST_RELEASE_DB;
                    dcnt_next  = '0;
                end else if (!repeat_en) begin
                    state_next = ST_HELD;
                    rcnt_next  = '0;
                end else if (rcnt_reg == RP_LAST) begin
                    repeat_next = 1'b1;
                    rcnt_next   = '0;
                end else begin
                    rcnt_next = rcnt_inc;
                end
            end
            ST_RELEASE_DB: begin
                // A bounce back high resumes the hold without a new press
                if (s) begin
                    state_next = ST_HELD;
                    rcnt_next  = '0;
                end else if (dcnt_reg == D_LAST) begin
                    state_next   = ST_IDLE;
                    release_next = 1'b1;
                    level_next   = 1'b0;
                end else begin
                    dcnt_next = dcnt_inc;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Register FSM state, counters and all outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            dcnt_reg    <= '0;
            rcnt_reg    <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            repeat_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dcnt_reg    <= dcnt_next;
            rcnt_reg    <= rcnt_next;
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            repeat_reg  <= repeat_next;
        end
    end

    assign level         = level_reg;
    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;
    assign repeat_pulse  = repeat_reg;

endmodule

// File: rtl/btn_conditioner.sv
// N_BTN independent button channels with debounce, edge pulses and
// auto-repeat; any_press flags a press on any channel.
module btn_conditioner
    import si_pkg::*;
#(
    parameter int N_BTN           = DEF_N_BTN,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic             any_press
);

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
            btn_channel #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD),
                .ACTIVE_LOW     (ACTIVE_LOW)
            ) u_ch (
                .clk          (clk),
                .rst          (rst),
                .raw          (btn_raw[gi]),
                .repeat_en    (repeat_en[gi]),
                .level        (btn_level[gi]),
                .press_pulse  (btn_press[gi]),
                .release_pulse(btn_release[gi]),
                .repeat_pulse (btn_repeat[gi])
            );
        end
    endgenerate

    // Press pulses are already registered, so the OR lines up with them
    assign any_press = |btn_press;

endmodule
